// File: rtl/mario_pixel_fetch_scheduler.sv
// Shares one synchronous sprite/tile memory between the Mario and ground fetchers, two reads per pixel.
// Latency: 3 cycles from accepted pix_ce to px_valid; a strobe during the second slot is dropped and flagged.
module mario_pixel_fetch_scheduler #(
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          TILE        = 32,
    parameter int          GROUND_Y    = 416,
    parameter int          MARIO_BASE  = 0,
    parameter int          GROUND_BASE = 1024,
    parameter logic [23:0] TRANSPARENT = 24'hFF00FF,
    parameter int          ADDR_W      = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_ce,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        MarioX,
    input  logic [9:0]        MarioY,
    input  logic              mario_dir,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [23:0]       mem_rdata,
    output logic              mario,
    output logic [23:0]       mario_pic_out,
    output logic [23:0]       ground,
    output logic              px_valid,
    output logic              overrun
);
    localparam int TB_W = $clog2(TILE);

    typedef enum logic {SLOT_A, SLOT_B} slot_e;

    slot_e             slot_q;
    logic [9:0]        mx_q, my_q;
    logic              dir_q;
    logic [ADDR_W-1:0] addr_q, gnd_addr_q;
    logic              spr_hit_q, gnd_hit_q, s1_vld_q;
    logic              stg_hit_q, gnd_hit2_q, s2_vld_q;
    logic [23:0]       stg_dat_q;
    logic              mario_q, px_valid_q, overrun_q;
    logic [23:0]       pic_q, gnd_q;

    logic              accept_d, frame0_d, dir_d, spr_hit_d, gnd_hit_d;
    logic [9:0]        mx_d, my_d, dx_d, dy_d, col_d;
    logic [TB_W-1:0]   yoff_d;
    logic [ADDR_W-1:0] spr_addr_d, gnd_addr_d;

    // The frame-start pixel sees the live position; all later pixels use the latched copy.
    always_comb begin
        accept_d   = pix_ce && (slot_q == SLOT_A) && !Reset;
        frame0_d   = (DrawX == 10'd0) && (DrawY == 10'd0);
        mx_d       = frame0_d ? MarioX : mx_q;
        my_d       = frame0_d ? MarioY : my_q;
        dir_d      = frame0_d ? mario_dir : dir_q;
        dx_d       = DrawX - mx_d;
        dy_d       = DrawY - my_d;
        spr_hit_d  = (dx_d < 10'(SPRITE_W)) && (dy_d < 10'(SPRITE_H));
        col_d      = dir_d ? (10'(SPRITE_W - 1) - dx_d) : dx_d;
        spr_addr_d = ADDR_W'(MARIO_BASE + int'(dy_d) * SPRITE_W + int'(col_d));
        gnd_hit_d  = DrawY >= 10'(GROUND_Y);
        yoff_d     = TB_W'(DrawY - 10'(GROUND_Y));
        gnd_addr_d = ADDR_W'(GROUND_BASE + int'(yoff_d) * TILE + int'(DrawX[TB_W-1:0]));
    end

    // Address must be on the bus in the strobe cycle itself, so the read port is combinational.
    always_comb begin
        mem_rd   = 1'b0;
        mem_addr = addr_q;
        if (accept_d && spr_hit_d) begin
            mem_rd   = 1'b1;
            mem_addr = spr_addr_d;
        end else if (!Reset && (slot_q == SLOT_B) && gnd_hit_q) begin
            mem_rd   = 1'b1;
            mem_addr = gnd_addr_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_q     <= SLOT_A;
            mx_q       <= '0;
            my_q       <= '0;
            dir_q      <= 1'b0;
            addr_q     <= '0;
            gnd_addr_q <= '0;
            spr_hit_q  <= 1'b0;
            gnd_hit_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            stg_hit_q  <= 1'b0;
            gnd_hit2_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            stg_dat_q  <= '0;
            mario_q    <= 1'b0;
            pic_q      <= '0;
            gnd_q      <= '0;
            px_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (slot_q == SLOT_A) begin
                if (pix_ce) slot_q <= SLOT_B;
            end else begin
                slot_q <= SLOT_A;
                if (pix_ce) overrun_q <= 1'b1;
            end
            if (accept_d && frame0_d) begin
                mx_q  <= MarioX;
                my_q  <= MarioY;
                dir_q <= mario_dir;
            end
            if (mem_rd) addr_q <= mem_addr;
            if (accept_d) gnd_addr_q <= gnd_addr_d;
            s1_vld_q   <= accept_d;
            spr_hit_q  <= accept_d && spr_hit_d;
            gnd_hit_q  <= accept_d && gnd_hit_d;
            // Sprite texel arrives one cycle before the ground texel and waits here.
            s2_vld_q   <= s1_vld_q;
            stg_hit_q  <= spr_hit_q;
            stg_dat_q  <= mem_rdata;
            gnd_hit2_q <= gnd_hit_q;
            px_valid_q <= s2_vld_q;
            if (s2_vld_q) begin
                mario_q <= stg_hit_q && (stg_dat_q != TRANSPARENT);
                pic_q   <= stg_hit_q ? stg_dat_q : 24'd0;
                gnd_q   <= gnd_hit2_q ? mem_rdata : 24'd0;
            end
        end
    end

    assign mario         = mario_q;
    assign mario_pic_out = pic_q;
    assign ground        = gnd_q;
    assign px_valid      = px_valid_q;
    assign overrun       = overrun_q;
endmodule

// File: doc/mario_pixel_fetch_scheduler.md
# mario_pixel_fetch_scheduler

Time-division scheduler that shares the single-port sprite/tile memory between the Mario sprite requester and the ground tile requester, once per VGA pixel. It computes both memory addresses from the beam position, issues them in two fixed slots, captures the returned texels, and presents `mario`, `mario_pic_out` and `ground` to the colour mapper. It sits between the VGA controller/Mario motion logic and the colour mapper.

## Interface
- `SPRITE_W`, 32: Mario sprite width in pixels, power of two.
- `SPRITE_H`, 32: Mario sprite height in pixels.
- `TILE`, 32: ground tile edge in pixels, power of two.
- `GROUND_Y`, 416: first scanline of the ground band.
- `MARIO_BASE`, 0: memory word address of sprite texel (0,0).
- `GROUND_BASE`, 1024: memory word address of tile texel (0,0).
- `TRANSPARENT`, 24'hFF00FF: sprite key colour.
- `ADDR_W`, 15: memory address width.
- `Clk`  in  1  system clock. Single clock domain.
- `Reset`  in  1  synchronous reset, active-high.
- `pix_ce`  in  1  pixel strobe, one cycle in every two; `DrawX`/`DrawY` are valid in that cycle.
- `DrawX`, `DrawY`  in  10 each  beam position.
- `MarioX`, `MarioY`  in  10 each  sprite top-left position.
- `mario_dir`  in  1  1 = facing left, mirrors the sprite horizontally.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rd`  out  1  read enable.
- `mem_rdata`  in  24  read data. Synchronous memory, 1-cycle latency.
- `mario`  out  1  current pixel is an opaque Mario texel.
- `mario_pic_out`  out  24  Mario texel, RGB888.
- `ground`  out  24  ground texel, RGB888.
- `px_valid`  out  1  one-cycle pulse when the outputs update.
- `overrun`  out  1  sticky flag for a `pix_ce` protocol violation.

## Operation
- Slot FSM with two states, SLOT_A and SLOT_B. Reset state is SLOT_A.
  - SLOT_A → SLOT_B on `pix_ce`. Otherwise the FSM stays in SLOT_A.
  - SLOT_B → SLOT_A unconditionally.
- `pix_ce` in SLOT_B is ignored and sets `overrun`. `overrun` clears only on reset.
- Frame latch: when `pix_ce` is high and DrawX = DrawY = 0, register `MarioX`, `MarioY` and `mario_dir`.
  - That pixel uses the incoming values directly.
  - Every other pixel uses the latched values, so the sprite never tears mid-frame.
- Sprite hit test uses 10-bit unsigned wrap arithmetic:
  - dx = DrawX − MX and dy = DrawY − MY.
  - Hit when dx < SPRITE_W and dy < SPRITE_H.
- Sprite column: col = `mario_dir` ? SPRITE_W−1−dx : dx.
- Sprite address: MARIO_BASE + dy·SPRITE_W + col.
- Ground hit: DrawY ≥ GROUND_Y.
- Ground address: GROUND_BASE + ((DrawY−GROUND_Y) mod TILE)·TILE + (DrawX mod TILE). Implement the mod as low-bit selects.
- All addresses are truncated to ADDR_W bits.
- Slot A (cycle with accepted `pix_ce`):
  - On sprite hit: `mem_rd`=1 and `mem_addr` = sprite address.
  - Otherwise: `mem_rd`=0 and `mem_addr` holds its previous value.
- Slot B (following cycle):
  - On ground hit: `mem_rd`=1 and `mem_addr` = ground address.
  - Otherwise: `mem_rd`=0.
- Each hit flag is piped alongside its read. Capture rules:
  - Sprite data: `mario` = hit AND `mem_rdata` ≠ TRANSPARENT. `mario_pic_out` = `mem_rdata` when the sprite hit, else 0.
  - Ground data: `ground` = `mem_rdata` when the ground hit, else 0.
- The memory is never accessed outside slots A and B. A read is issued at most once per cycle.

## Timing
- Accepted `pix_ce` in cycle t:
  - t: sprite address issued.
  - t+1: sprite data returns and goes to a staging register; ground address issued.
  - t+2: ground data returns.
  - `mario`, `mario_pic_out` and `ground` all update together on the edge ending t+2.
  - `px_valid`=1 during t+3 only.
- Pixel-to-output latency is 3 cycles. Pixels pipeline back-to-back: the next `pix_ce` may arrive at t+2.
- Reset values: `mem_addr`=0, `mem_rd`=0, `mario`=0, `mario_pic_out`=0, `ground`=0, `px_valid`=0, `overrun`=0. Latched position and direction are 0.
- Reset asserted mid-pixel discards all in-flight reads. No `px_valid` follows for them.
- Outputs hold their values between `px_valid` pulses.

## Test plan
- Sprite fetch: MarioX=100, MarioY=200, dir=0; pixel (105,210).
  - Cycle t: `mem_rd`=1, `mem_addr`=325.
  - With rdata=24'h123456: `mario`=1 and `mario_pic_out`=24'h123456 at t+3, with `px_valid`=1.
- Mirror: same setup with `mario_dir`=1 latched at frame start → `mem_addr`=346.
- Ground and key colour: pixel (70,420), Mario elsewhere.
  - Slot A: `mem_rd`=0.
  - Slot B: `mem_addr`=1158.
  - Outputs: `ground`=returned texel, `mario`=0.
  - Then place Mario over the pixel with sprite rdata=24'hFF00FF → `mario`=0.
- Tear-free latch: change MarioX from 100 to 300 while DrawY=150.
  - Pixels at DrawY=200 still hit at X=100..131 and not at X=300.
  - After the next (0,0) pixel, hits move to X=300..331.
- Protocol and reset:
  - Assert `pix_ce` on two consecutive cycles → second strobe ignored, `overrun`=1 and stays 1.
  - Assert `Reset` at t+1 of a pixel → no `px_valid`, all outputs 0, `overrun`=0 at the next cycle.
- Sprite address wrap: MarioX=1020 (wrap), DrawX=2 → dx=6 is a hit, address row·32+6. DrawX=1019 → no hit.
